// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO: configurable width, parity, stop bits.
// Ports: clk, reset (async high), w_data/wr_uart (enqueue), tx (serial out),
// tx_full/tx_empty/level (FIFO status), tx_busy, overflow (sticky), probe.
module uart_tx_fifo #(
  parameter int DIVISOR        = 13,
  parameter int DVSR_BIT       = 7,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_ADDR_BITS = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_BITS-1:0]      w_data,
  input  logic                      wr_uart,
  output logic                      tx,
  output logic                      tx_full,
  output logic                      tx_empty,
  output logic                      tx_busy,
  output logic                      overflow,
  output logic [FIFO_ADDR_BITS:0]   level,
  output logic [3:0]                probe
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [FIFO_ADDR_BITS:0] FULL_LVL =
    (FIFO_ADDR_BITS+1)'(DEPTH);
  localparam logic [DVSR_BIT-1:0] DIV_LAST = DVSR_BIT'(DIVISOR-1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS-1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS-1);
  localparam logic ODD     = (PARITY == 2);
  localparam logic HAS_PAR = (PARITY != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || DIVISOR < 1 ||
      FIFO_ADDR_BITS < 1 || (2**DVSR_BIT) <= DIVISOR) begin : g_bad
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_BITS:0]   level_n;
  logic                      push, pop;

  state_t                    state, state_n;
  logic [DVSR_BIT-1:0]       div_cnt;
  logic [3:0]                tick_cnt;
  logic [3:0]                bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]      shift, head;
  logic                      par, tx_n, restart, bit_end;

  // Full is judged on the registered flag, so a write never
  // sneaks in on the strength of a pop in the same cycle.
  assign push    = wr_uart & ~tx_full;
  assign head    = mem[rd_ptr];
  assign level_n = level + {{FIFO_ADDR_BITS{1'b0}}, push}
                         - {{FIFO_ADDR_BITS{1'b0}}, pop};
  assign bit_end = (state != S_IDLE) && (div_cnt == DIV_LAST)
                && (tick_cnt == 4'd15);
  assign tx_busy = (state != S_IDLE);
  assign probe   = {1'b0, state};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_n;
      tx_full  <= (level_n == FULL_LVL);
      tx_empty <= (level_n == '0);
      if (wr_uart && tx_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      tick_cnt <= '0;
      shift    <= '0;
      par      <= 1'b0;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      bit_cnt <= bit_cnt_n;
      // Counters restart with each frame so bit edges stay exact.
      if (restart || state == S_IDLE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 4'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (pop) begin
        shift <= head;
        par   <= (^head) ^ ODD;
      end else if (state == S_DATA && bit_end) begin
        shift <= shift >> 1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    bit_cnt_n = bit_cnt;
    pop       = 1'b0;
    restart   = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!tx_empty) begin
          pop     = 1'b1;
          restart = 1'b1;
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
          tx_n      = shift[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            if (HAS_PAR) begin
              state_n = S_PARITY;
              tx_n    = par;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            tx_n      = shift[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n   = S_STOP;
          bit_cnt_n = '0;
          tx_n      = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            if (!tx_empty) begin
              pop     = 1'b1;
              restart = 1'b1;
              state_n = S_START;
              tx_n    = 1'b0;
            end else begin
              state_n = S_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 8E1,
// 8O1 and 8N2 framing, FIFO fill/overflow and asynchronous reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] w_data [4];
  logic [3:0] wr = '0;
  logic [3:0] tx, tx_full, tx_empty, tx_busy, overflow;
  logic [5:0] level [4];
  logic [3:0] probe [4];

  int nvec = 0;
  int nerr = 0;
  int bc [4];
  logic [3:0] tr [0:799];
  logic [3:0] br [0:799];
  int starts = 0;
  logic [3:0] pprev = '0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DIVISOR(2), .DVSR_BIT(2), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_ADDR_BITS(5)) u0 (
    .clk(clk), .reset(reset), .w_data(w_data[0]), .wr_uart(wr[0]),
    .tx(tx[0]), .tx_full(tx_full[0]), .tx_empty(tx_empty[0]),
    .tx_busy(tx_busy[0]), .overflow(overflow[0]), .level(level[0]),
    .probe(probe[0]));

  uart_tx_fifo #(.DIVISOR(2), .DVSR_BIT(2), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(1), .FIFO_ADDR_BITS(5)) u1 (
    .clk(clk), .reset(reset), .w_data(w_data[1]), .wr_uart(wr[1]),
    .tx(tx[1]), .tx_full(tx_full[1]), .tx_empty(tx_empty[1]),
    .tx_busy(tx_busy[1]), .overflow(overflow[1]), .level(level[1]),
    .probe(probe[1]));

  uart_tx_fifo #(.DIVISOR(2), .DVSR_BIT(2), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_ADDR_BITS(5)) u2 (
    .clk(clk), .reset(reset), .w_data(w_data[2]), .wr_uart(wr[2]),
    .tx(tx[2]), .tx_full(tx_full[2]), .tx_empty(tx_empty[2]),
    .tx_busy(tx_busy[2]), .overflow(overflow[2]), .level(level[2]),
    .probe(probe[2]));

  uart_tx_fifo #(.DIVISOR(2), .DVSR_BIT(2), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(2), .FIFO_ADDR_BITS(5)) u3 (
    .clk(clk), .reset(reset), .w_data(w_data[3]), .wr_uart(wr[3]),
    .tx(tx[3]), .tx_full(tx_full[3]), .tx_empty(tx_empty[3]),
    .tx_busy(tx_busy[3]), .overflow(overflow[3]), .level(level[3]),
    .probe(probe[3]));

  // Frames started on u0: each entry into START (probe==1).
  always @(negedge clk) begin
    if (probe[0] == 4'd1 && pprev != 4'd1) starts++;
    pprev = probe[0];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cap(int i);
    tr[i] = tx;
    br[i] = tx_busy;
    for (int j = 0; j < 4; j++) bc[j] += int'(tx_busy[j]);
  endtask

  task automatic clr_bc();
    for (int j = 0; j < 4; j++) bc[j] = 0;
  endtask

  initial begin
    logic [9:0]  f1;
    logic [21:0] f3;
    int s0;
    for (int j = 0; j < 4; j++) w_data[j] = '0;

    // Reset values, checked while reset is still asserted.
    repeat (3) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      chk("rst_tx", 32'(tx[j]), 1);
      chk("rst_full", 32'(tx_full[j]), 0);
      chk("rst_empty", 32'(tx_empty[j]), 1);
      chk("rst_busy", 32'(tx_busy[j]), 0);
      chk("rst_ovf", 32'(overflow[j]), 0);
      chk("rst_level", 32'(level[j]), 0);
      chk("rst_probe", 32'(probe[j]), 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1, 0x55: 320-clock frame, tx low one edge after the write.
    w_data[0] = 8'h55; wr[0] = 1'b1;
    @(negedge clk);
    wr[0] = 1'b0;
    chk("t1_tx_pre", 32'(tx[0]), 1);
    chk("t1_level", 32'(level[0]), 1);
    chk("t1_empty", 32'(tx_empty[0]), 0);
    clr_bc();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cap(i);
    end
    chk("t1_tx_first", 32'(tr[0][0]), 0);
    chk("t1_probe_start", 32'(br[0][0]), 1);
    f1 = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++)
      chk($sformatf("t1_bit%0d", k), 32'(tr[32*k+16][0]), 32'(f1[k]));
    chk("t1_start_end", 32'(tr[31][0]), 0);
    chk("t1_d0_begin", 32'(tr[32][0]), 1);
    chk("t1_busy_clks", 32'(bc[0]), 320);
    chk("t1_idle_tx", 32'(tr[320][0]), 1);
    chk("t1_idle_busy", 32'(br[320][0]), 0);

    // 0x07 with even (u1) and odd (u2) parity: 352-clock frames.
    w_data[1] = 8'h07; w_data[2] = 8'h07; wr[2:1] = 2'b11;
    @(negedge clk);
    wr[2:1] = 2'b00;
    clr_bc();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cap(i);
    end
    chk("t2_even_d2", 32'(tr[3*32+16][1]), 1);
    chk("t2_even_d3", 32'(tr[4*32+16][1]), 0);
    chk("t2_even_par", 32'(tr[9*32+16][1]), 1);
    chk("t2_odd_par", 32'(tr[9*32+16][2]), 0);
    chk("t2_even_stop", 32'(tr[10*32+16][1]), 1);
    chk("t2_odd_stop", 32'(tr[10*32+16][2]), 1);
    chk("t2_even_clks", 32'(bc[1]), 352);
    chk("t2_odd_clks", 32'(bc[2]), 352);

    // 8N2: 0xA3 then 0x3C back to back, no idle clock between.
    w_data[3] = 8'hA3; wr[3] = 1'b1;
    @(negedge clk);
    w_data[3] = 8'h3C;
    @(negedge clk);
    wr[3] = 1'b0;
    clr_bc();
    cap(0);
    for (int i = 1; i < 800; i++) begin
      @(negedge clk);
      cap(i);
    end
    f3 = {2'b11, 8'h3C, 1'b0, 2'b11, 8'hA3, 1'b0};
    for (int k = 0; k < 22; k++)
      chk($sformatf("t3_bit%0d", k), 32'(tr[32*k+16][3]), 32'(f3[k]));
    s0 = 0;
    for (int i = 288; i < 352; i++) s0 += int'(tr[i][3]);
    chk("t3_stop_clks", 32'(s0), 64);
    chk("t3_stop_last", 32'(tr[351][3]), 1);
    chk("t3_start2", 32'(tr[352][3]), 0);
    chk("t3_busy_clks", 32'(bc[3]), 704);
    chk("t3_idle", 32'(br[704][3]), 0);

    // Fill: primer frame keeps u0 busy while 32 words fill the FIFO.
    s0 = starts;
    w_data[0] = 8'hC3; wr[0] = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      w_data[0] = 8'(k);
    end
    @(negedge clk);
    chk("t4_level32", 32'(level[0]), 32);
    chk("t4_full", 32'(tx_full[0]), 1);
    chk("t4_ovf_pre", 32'(overflow[0]), 0);
    w_data[0] = 8'hEE;
    @(negedge clk);
    wr[0] = 1'b0;
    chk("t4_ovf", 32'(overflow[0]), 1);
    chk("t4_level_kept", 32'(level[0]), 32);
    chk("t4_full_kept", 32'(tx_full[0]), 1);

    // Write while full on the edge the primer's stop bit ends.
    repeat (321 - 34) @(negedge clk);
    chk("t5_in_stop", 32'(probe[0]), 4);
    chk("t5_level_pre", 32'(level[0]), 32);
    w_data[0] = 8'h99; wr[0] = 1'b1;
    @(negedge clk);
    wr[0] = 1'b0;
    chk("t5_level31", 32'(level[0]), 31);
    chk("t5_full_clr", 32'(tx_full[0]), 0);
    chk("t5_ovf", 32'(overflow[0]), 1);
    chk("t5_restart", 32'(probe[0]), 1);
    repeat (33 * 320 - 322 + 200) @(negedge clk);
    chk("t4_frames", 32'(starts - s0), 33);
    chk("t4_empty_end", 32'(tx_empty[0]), 1);
    chk("t4_level_end", 32'(level[0]), 0);
    chk("t4_busy_end", 32'(tx_busy[0]), 0);
    chk("t4_ovf_sticky", 32'(overflow[0]), 1);

    // Reset in data bit 4 of 0xFF with a second word still queued.
    w_data[0] = 8'hFF; wr[0] = 1'b1;
    @(negedge clk);
    w_data[0] = 8'h00;
    @(negedge clk);
    wr[0] = 1'b0;
    repeat (170) @(negedge clk);
    chk("t6_in_data", 32'(probe[0]), 2);
    chk("t6_level", 32'(level[0]), 1);
    s0 = starts;
    reset = 1'b1;
    #1;
    chk("t6_async_tx", 32'(tx[0]), 1);
    chk("t6_async_busy", 32'(tx_busy[0]), 0);
    chk("t6_async_probe", 32'(probe[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_empty", 32'(tx_empty[0]), 1);
    chk("t6_level0", 32'(level[0]), 0);
    chk("t6_probe0", 32'(probe[0]), 0);
    chk("t6_ovf_clr", 32'(overflow[0]), 0);
    repeat (400) @(negedge clk);
    chk("t6_no_frames", 32'(starts - s0), 0);
    chk("t6_tx_idle", 32'(tx[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
